donut_march_ctl: RTL and testbench

Sequencing controller for the donut ray-march hit-test datapath. It accepts one ray per handshake and pulses the datapath's `start`. It then counts march iterations, samples the datapath's `hit`/`light` at the decided cycle, and delivers tagged results through a 2-entry output buffer to the VGA pixel pipeline. Ray origin, direction and light vectors route from the requester straight to the datapath. This block owns only timing and flow control.

---
 rtl/donut_pkg.sv | 41 ++++
 rtl/donut_res_fifo.sv | 57 +++++
 rtl/donut_march_ctl.sv | 142 ++++++++++++++
 tb/tb_donut_march_ctl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/donut_pkg.sv
// Shared types and helpers for the donut ray-march sequencing controller.
// Optional feature macro used by donut_march_ctl: DONUT_EARLY_EXIT_EN.
package donut_pkg;

    localparam int DONUT_STEPS_DEFAULT = 8;
    localparam int DONUT_STEP_W        = 4;
    localparam int DONUT_SHADE_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MARCH   = 2'd1,
        ST_CAPTURE = 2'd2
    } donut_state_e;

    // Per-ray result flags; the tag rides alongside because its width is a
    // parameter of the controller.
    typedef struct packed {
        logic                     hit;
        logic [DONUT_SHADE_W-1:0] shade;
        logic [DONUT_STEP_W-1:0]  steps;
    } donut_res_t;

    // Shade is the integer part of the light value, zero on a miss or on
    // non-positive light, saturated at 0x7F near full scale.
    function automatic logic [DONUT_SHADE_W-1:0] donut_shade(
        input logic              hit,
        input logic signed [15:0] light
    );
        logic [DONUT_SHADE_W-1:0] s;
        s = '0;
        if (!hit || (light <= 16'sd0)) begin
            s = 8'h00;
        end else if (light >= 16'sh7F00) begin
            s = 8'h7F;
        end else begin
            s = light[15:8];
        end
        return s;
    endfunction

endpackage

// File: rtl/donut_res_fifo.sv
// Two-entry valid/ready result buffer. Push and pop may coincide at any
// occupancy; the producer guarantees it never pushes while full.
module donut_res_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         full,
    output logic         full_after_push
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign full      = (count == 2'd2);
    // Occupancy seen by a push this cycle, after any simultaneous pop.
    assign full_after_push = (count == 2'd2) || ((count == 2'd1) && !pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage; cleared on reset so the result outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/donut_march_ctl.sv
// Sequencing controller for the donut ray-march hit-test datapath: accepts
// one ray per handshake, pulses dh_start, times the march, captures the
// datapath result and buffers it for the pixel pipeline.
// Optional feature: define DONUT_EARLY_EXIT_EN to end a march as soon as the
// (sticky-low) datapath hit flag drops.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a ray; ready whenever the result buffer has room
// ST_MARCH   | datapath stepping; step_cnt counts completed steps
// ST_CAPTURE | sample hit/light, push result, may accept the next ray
module donut_march_ctl
    import donut_pkg::*;
#(
    parameter int STEPS = DONUT_STEPS_DEFAULT,
    parameter int TAG_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              dh_start,
    input  logic              dh_hit,
    input  logic signed [15:0] dh_light,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_hit,
    output logic [7:0]        res_light,
    output logic [3:0]        res_steps
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        donut_res_t       res;
    } entry_t;

    localparam logic [DONUT_STEP_W-1:0] STEP_LAST = DONUT_STEP_W'(STEPS - 1);

    donut_state_e            state;
    donut_state_e            state_nxt;
    logic [DONUT_STEP_W-1:0] step_cnt;
    logic [TAG_W-1:0]        tag_q;
    logic                    busy_q;
    logic                    accept;
    logic                    push;
    logic                    early_miss;
    logic                    fifo_full;
    logic                    fifo_full_after_push;
    entry_t                  push_entry;
    entry_t                  head_entry;

`ifdef DONUT_EARLY_EXIT_EN
    // From the second march cycle on, a dropped hit flag ends the march.
    assign early_miss = (step_cnt != '0) && !dh_hit;
`else
    assign early_miss = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, handshake readiness and capture push.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = rst_n & ~fifo_full;
                accept    = req_valid & req_ready;
                if (accept) state_nxt = ST_MARCH;
            end
            ST_MARCH: begin
                if ((step_cnt == STEP_LAST) || early_miss) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                push      = 1'b1;
                req_ready = rst_n & ~fifo_full_after_push;
                accept    = req_valid & req_ready;
                state_nxt = accept ? ST_MARCH : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dh_start = accept;

    // Step counter, tag latch and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
            tag_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (accept) begin
                step_cnt <= '0;
                tag_q    <= req_tag;
            end else if (state == ST_MARCH) begin
                step_cnt <= step_cnt + 1'b1;
            end
            busy_q <= (state_nxt == ST_MARCH);
        end
    end

    assign busy = busy_q;

    // Result assembled from the datapath sample taken in the capture cycle.
    always_comb begin
        push_entry           = '0;
        push_entry.tag       = tag_q;
        push_entry.res.hit   = dh_hit;
        push_entry.res.shade = donut_shade(dh_hit, dh_light);
        push_entry.res.steps = step_cnt;
    end

    donut_res_fifo #(
        .W ($bits(entry_t))
    ) u_res_fifo (
        .clk             (clk),
        .rst_n           (rst_n),
        .push            (push),
        .push_data       (push_entry),
        .out_valid       (res_valid),
        .out_ready       (res_ready),
        .out_data        (head_entry),
        .full            (fifo_full),
        .full_after_push (fifo_full_after_push)
    );

    assign res_tag   = head_entry.tag;
    assign res_hit   = head_entry.res.hit;
    assign res_light = head_entry.res.shade;
    assign res_steps = head_entry.res.steps;

endmodule

// File: tb/tb_donut_march_ctl.sv
// Bench for donut_march_ctl: directed scenarios plus a randomized run, all
// checked every cycle against a ray-level reference model (accept time,
// capture time and result per ray, FIFO as a queue).
module tb_donut_march_ctl;

    localparam int STEPS = 8;
    localparam int TAG_W = 10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid;
    logic               req_ready;
    logic [TAG_W-1:0]   req_tag;
    logic               dh_start;
    logic               dh_hit;
    logic signed [15:0] dh_light;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [TAG_W-1:0]   res_tag;
    logic               res_hit;
    logic [7:0]         res_light;
    logic [3:0]         res_steps;

    always #5 clk = ~clk;

    donut_march_ctl #(.STEPS(STEPS), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .dh_start  (dh_start),
        .dh_hit    (dh_hit),
        .dh_light  (dh_light),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_tag   (res_tag),
        .res_hit   (res_hit),
        .res_light (res_light),
        .res_steps (res_steps)
    );

    typedef struct {
        int tag;
        int hit;
        int shade;
        int steps;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   m_inflight = 1'b0;
    int   m_acc, m_cap, m_drop, m_light;
    exp_t m_res;
    int   nxt_drop  = 1000;
    int   nxt_light = 0;
    logic last_start;
    int   starts[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int shade_of(input int hit, input int light);
        int s;
        if (hit == 0 || light <= 0) return 0;
        s = light / 256;
        return (s > 127) ? 127 : s;
    endfunction

    // A ray's whole life is decided at accept: when it is captured, what it reports.
    task automatic start_ray(input int tag);
        int st;
`ifdef DONUT_EARLY_EXIT_EN
        int k;
`endif
        m_inflight = 1'b1;
        m_acc      = cyc;
        m_drop     = nxt_drop;
        m_light    = nxt_light;
        st         = STEPS;
`ifdef DONUT_EARLY_EXIT_EN
        k = (m_drop < 2) ? 2 : m_drop;
        if (k <= STEPS) st = k;
`endif
        m_cap       = cyc + st + 1;
        m_res.tag   = tag;
        m_res.hit   = (st + 1 < m_drop) ? 1 : 0;
        m_res.shade = shade_of(m_res.hit, m_light);
        m_res.steps = st;
    endtask

    task automatic run_cycle(input bit v, input bit rr);
        int   rel;
        int   occ;
        bit   cap_now, pop_now, acc, exp_ready;
        exp_t dummy;
        logic [TAG_W-1:0] t;
        @(negedge clk);
        req_valid = v;
        res_ready = rr;
        t         = TAG_W'($urandom);
        req_tag   = t;
        if (m_inflight) begin
            rel      = cyc - m_acc;
            dh_hit   = (rel < m_drop);
            dh_light = 16'(m_light);
        end else begin
            dh_hit   = 1'($urandom);
            dh_light = 16'($urandom);
        end
        #2;
        occ     = q.size();
        cap_now = m_inflight && (cyc == m_cap);
        pop_now = rr && (occ > 0);
        if (!m_inflight)  exp_ready = (occ < 2);
        else if (cap_now) exp_ready = ((occ + 1 - int'(pop_now)) < 2);
        else              exp_ready = 1'b0;
        acc = v && exp_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("dh_start",  32'(dh_start),  32'(acc));
        chk("busy",      32'(busy),      32'(m_inflight && !cap_now));
        chk("res_valid", 32'(res_valid), 32'(occ > 0));
        if (occ > 0) begin
            chk("res_tag",   32'(res_tag),   32'(q[0].tag));
            chk("res_hit",   32'(res_hit),   32'(q[0].hit));
            chk("res_light", 32'(res_light), 32'(q[0].shade));
            chk("res_steps", 32'(res_steps), 32'(q[0].steps));
        end
        last_start = dh_start;
        if (pop_now) dummy = q.pop_front();
        if (cap_now) begin
            q.push_back(m_res);
            m_inflight = 1'b0;
        end
        if (acc) start_ray(int'(t));
        cyc++;
    endtask

    task automatic one_ray(input int drop, input int light);
        nxt_drop  = drop;
        nxt_light = light;
        run_cycle(1'b1, 1'b1);
        repeat (STEPS + 4) run_cycle(1'b0, 1'b1);
    endtask

    initial begin
        logic signed [15:0] r16;
        int sel;
        req_valid = 1'b1;
        req_tag   = '0;
        dh_hit    = 1'b0;
        dh_light  = '0;
        res_ready = 1'b0;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dh_start",  32'(dh_start),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_tag",   32'(res_tag),   32'd0);
        chk("rst_res_hit",   32'(res_hit),   32'd0);
        chk("rst_res_light", 32'(res_light), 32'd0);
        chk("rst_res_steps", 32'(res_steps), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Single hit ray, miss ray, and both clamp ends.
        one_ray(1000, 32'h3A40);
        one_ray(3, 32'h4000);
        one_ray(1000, -5);
        one_ray(1000, 32'h7FFF);
        one_ray(1, 32'h0100);

        // Back-pressure: three back-to-back requests with the consumer stalled.
        nxt_drop  = 1000;
        nxt_light = 32'h1234;
        repeat (40) run_cycle(1'b1, 1'b0);
        repeat (40) run_cycle(1'b0, 1'b1);

        // Streaming: accept times must be multiples of STEPS+1.
        starts.delete();
        for (int i = 0; i < 45; i++) begin
            run_cycle(1'b1, 1'b1);
            if (last_start) starts.push_back(i);
        end
        chk("stream_count", 32'(starts.size()), 32'd5);
        for (int j = 0; j < starts.size() && j < 5; j++)
            chk("stream_start", 32'(starts[j]), 32'(j * (STEPS + 1)));
        repeat (STEPS + 4) run_cycle(1'b0, 1'b1);

        // Reset in the middle of a march with a result already buffered.
        nxt_drop  = 1000;
        nxt_light = 32'h2000;
        run_cycle(1'b1, 1'b0);
        repeat (STEPS + 2) run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        repeat (3) run_cycle(1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
        q.delete();
        m_inflight = 1'b0;
        one_ray(1000, 32'h5500);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            nxt_drop = int'($urandom_range(1, STEPS + 3));
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: nxt_light = -5;
                1: nxt_light = 0;
                2: nxt_light = 32'h7F00;
                3: nxt_light = 32'h7EFF;
                4: nxt_light = 32'h7FFF;
                5: nxt_light = -32768;
                default: begin
                    r16 = 16'($urandom);
                    nxt_light = int'(r16);
                end
            endcase
            run_cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
        end
        repeat (2 * STEPS + 6) run_cycle(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
